// File: rtl/basilisk_reg_scoreboard.sv
// Register scoreboard: one saturating pending-write counter per architectural register.
// Latency: issue_ready is combinational from the counters; counter and reg_busy updates appear the next cycle.
// Backpressure: issue_ready drops while a dependency is pending, during flush and during rst. It never depends on issue_valid.
//
// Ports: clk/rst (synchronous, active-high); flush clears all counters.
//        issue_valid/issue_ready/issue_dep{rs3,rs2,rs1,rd}/issue_rd/rs1/rs2/rs3 form the decode handshake.
//        wb_valid/wb_rd are per-port writeback retire strobes.
//        reg_busy is a per-register pending flag. underflow_err is sticky and clears only on rst.
// Optional feature: define BASILISK_SCOREBOARD_BYPASS_EN to let a source with one pending write
// that is retiring this cycle count as ready.
module basilisk_reg_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int NUM_WB_PORTS = 2,
  parameter int CNT_WIDTH    = 3,
  parameter int WAW_ALLOW    = 0,
  localparam int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [3:0]                    issue_dep,
  input  logic [IDX_W-1:0]              issue_rd,
  input  logic [IDX_W-1:0]              issue_rs1,
  input  logic [IDX_W-1:0]              issue_rs2,
  input  logic [IDX_W-1:0]              issue_rs3,
  input  logic [NUM_WB_PORTS-1:0]       wb_valid,
  input  logic [NUM_WB_PORTS*IDX_W-1:0] wb_rd,
  output logic [NUM_REGS-1:0]           reg_busy,
  output logic                          underflow_err
);

  localparam int HIT_W = $clog2(NUM_WB_PORTS + 1);
  // Wide enough to hold counter + 1 and up to NUM_WB_PORTS decrements without wrapping.
  localparam int SUM_W = CNT_WIDTH + HIT_W + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] cnt_q   [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d   [NUM_REGS];
  logic [HIT_W-1:0]     hit_cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  src_rdy;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 underflow_q, underflow_d;
  logic                 srcs_ok, rd_ok, accept_rd;

  // Count how many writeback ports retire each register this cycle.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      hit_cnt[r] = '0;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (wb_valid[p] && (wb_rd[p*IDX_W +: IDX_W] == IDX_W'(r))) begin
          hit_cnt[r] = hit_cnt[r] + HIT_W'(1);
        end
      end
    end
  end

  // Per-register source readiness. With bypass, the last outstanding write
  // retiring this cycle is good enough; the execute stage forwards the data.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
`ifdef BASILISK_SCOREBOARD_BYPASS_EN
      src_rdy[r] = (cnt_q[r] == '0) ||
                   ((cnt_q[r] == CNT_WIDTH'(1)) && (hit_cnt[r] != '0));
`else
      src_rdy[r] = (cnt_q[r] == '0);
`endif
    end
  end

  // Issue gate. The rd check is never bypassed.
  always_comb begin
    srcs_ok = (!issue_dep[1] || src_rdy[issue_rs1]) &&
              (!issue_dep[2] || src_rdy[issue_rs2]) &&
              (!issue_dep[3] || src_rdy[issue_rs3]);
    if (WAW_ALLOW != 0) begin
      rd_ok = !issue_dep[0] || (cnt_q[issue_rd] != CNT_MAX);
    end else begin
      rd_ok = !issue_dep[0] || (cnt_q[issue_rd] == '0);
    end
    issue_ready = srcs_ok && rd_ok && !flush && !rst;
    accept_rd   = issue_valid && issue_ready && issue_dep[0];
  end

  // Net counter update: +1 for an accepted issue, -k for k writeback hits,
  // clamped at zero with the underflow flagged.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] dec;
    sum         = '0;
    dec         = '0;
    underflow_d = underflow_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      sum = SUM_W'(cnt_q[r]) + SUM_W'(accept_rd && (issue_rd == IDX_W'(r)));
      dec = SUM_W'(hit_cnt[r]);
      if (flush) begin
        cnt_d[r] = '0;
      end else if (dec > sum) begin
        cnt_d[r]    = '0;
        underflow_d = 1'b1;
      end else begin
        cnt_d[r] = CNT_WIDTH'(sum - dec);
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q      <= busy_d;
      underflow_q <= underflow_d;
    end
  end

  assign reg_busy      = busy_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_basilisk_reg_scoreboard.sv
module tb_basilisk_reg_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration DUT (WAW_ALLOW=0)
  logic        rst, flush, issue_valid, issue_ready, underflow_err;
  logic [3:0]  issue_dep;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2, issue_rs3;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic [31:0] reg_busy;

  // WAW_ALLOW=1 DUT for the saturation and same-cycle issue+writeback cases
  logic        w_rst, w_flush, w_valid, w_ready, w_err;
  logic [3:0]  w_dep;
  logic [4:0]  w_rd, w_rs1, w_rs2, w_rs3;
  logic [1:0]  w_wbv;
  logic [9:0]  w_wbrd;
  logic [31:0] w_busy;

  basilisk_reg_scoreboard u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_dep(issue_dep),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .reg_busy(reg_busy), .underflow_err(underflow_err)
  );

  basilisk_reg_scoreboard #(.WAW_ALLOW(1)) u_waw (
    .clk(clk), .rst(w_rst), .flush(w_flush),
    .issue_valid(w_valid), .issue_ready(w_ready), .issue_dep(w_dep),
    .issue_rd(w_rd), .issue_rs1(w_rs1), .issue_rs2(w_rs2), .issue_rs3(w_rs3),
    .wb_valid(w_wbv), .wb_rd(w_wbrd), .reg_busy(w_busy), .underflow_err(w_err)
  );

  typedef struct {
    logic        rst, flush, valid;
    logic [3:0]  dep;
    logic [4:0]  rd, rs1, rs2, rs3;
    logic [1:0]  wbv;
    logic [4:0]  wb0, wb1;
    logic        exp_rdy;
    logic [31:0] exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic r, logic f, logic v, logic [3:0] dep,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rs3,
                              logic [1:0] wbv, logic [4:0] wb0, logic [4:0] wb1,
                              logic rdy, logic [31:0] busy, logic err);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = v; t.dep = dep;
    t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.rs3 = rs3;
    t.wbv = wbv; t.wb0 = wb0; t.wb1 = wb1;
    t.exp_rdy = rdy; t.exp_busy = busy; t.exp_err = err;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic w_drive(input logic v, input logic [4:0] rd,
                         input logic [1:0] wbv, input logic [4:0] wb0, input logic [4:0] wb1);
    @(negedge clk);
    w_valid = v; w_dep = v ? 4'b0001 : 4'b0000; w_rd = rd;
    w_wbv = wbv; w_wbrd = {wb1, wb0};
    #1;
  endtask

  logic bypass_rdy;

  initial begin
`ifdef BASILISK_SCOREBOARD_BYPASS_EN
    bypass_rdy = 1'b1;
`else
    bypass_rdy = 1'b0;
`endif
    //             rst flush v  dep      rd  rs1 rs2 rs3 wbv    wb0 wb1 rdy  busy          err
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0,  0,  0,  0,  2'b00, 0,  0,  0,   32'h0,        0)); // reset
    vecs.push_back(mk(0, 0, 1, 4'b0001, 5,  0,  0,  0,  2'b00, 0,  0,  1,   32'h20,       0)); // issue rd=5
    vecs.push_back(mk(0, 0, 1, 4'b0010, 0,  5,  0,  0,  2'b00, 0,  0,  0,   32'h20,       0)); // rs1=5 blocked
    vecs.push_back(mk(0, 0, 1, 4'b0010, 0,  5,  0,  0,  2'b01, 5,  0,  bypass_rdy, 32'h0, 0)); // wb 5
    vecs.push_back(mk(0, 0, 1, 4'b0010, 0,  5,  0,  0,  2'b00, 0,  0,  1,   32'h0,        0)); // rs1=5 ready
    vecs.push_back(mk(0, 0, 1, 4'b0001, 7,  0,  0,  0,  2'b00, 0,  0,  1,   32'h80,       0)); // issue rd=7
    vecs.push_back(mk(0, 0, 1, 4'b0001, 7,  0,  0,  0,  2'b10, 0,  7,  0,   32'h0,        0)); // rd never bypassed
    vecs.push_back(mk(0, 0, 1, 4'b0001, 2,  0,  0,  0,  2'b00, 0,  0,  1,   32'h4,        0));
    vecs.push_back(mk(0, 0, 1, 4'b0001, 1,  0,  0,  0,  2'b00, 0,  0,  1,   32'h6,        0));
    vecs.push_back(mk(0, 0, 1, 4'b0001, 4,  0,  0,  0,  2'b00, 0,  0,  1,   32'h16,       0));
    vecs.push_back(mk(0, 1, 1, 4'b0001, 10, 0,  0,  0,  2'b01, 1,  0,  0,   32'h0,        0)); // flush
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0,  0,  0,  0,  2'b01, 9,  0,  1,   32'h0,        1)); // underflow
    vecs.push_back(mk(0, 0, 1, 4'b1000, 0,  0,  0,  9,  2'b00, 0,  0,  1,   32'h0,        1)); // err sticky
    vecs.push_back(mk(0, 0, 1, 4'b0101, 6,  0,  6,  0,  2'b00, 0,  0,  1,   32'h40,       1));
    vecs.push_back(mk(0, 1, 0, 4'b0000, 0,  0,  0,  0,  2'b00, 0,  0,  0,   32'h0,        1)); // flush holds err
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0,  0,  0,  0,  2'b11, 6,  6,  1,   32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0,  0,  0,  0,  2'b00, 0,  0,  0,   32'h0,        0)); // rst clears err
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0,  0,  0,  0,  2'b10, 0,  3,  1,   32'h0,        1)); // stale wb
    vecs.push_back(mk(1, 0, 0, 4'b0000, 0,  0,  0,  0,  2'b00, 0,  0,  0,   32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 4'b0001, 8,  0,  0,  0,  2'b00, 0,  0,  1,   32'h100,      0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 0,  0,  0,  0,  2'b11, 8,  8,  1,   32'h0,        1)); // 2 wb, cnt 1

    w_rst = 1'b1; w_flush = 1'b0; w_valid = 1'b0; w_dep = '0;
    w_rd = '0; w_rs1 = '0; w_rs2 = '0; w_rs3 = '0; w_wbv = '0; w_wbrd = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush; issue_valid = vecs[i].valid;
      issue_dep = vecs[i].dep; issue_rd = vecs[i].rd;
      issue_rs1 = vecs[i].rs1; issue_rs2 = vecs[i].rs2; issue_rs3 = vecs[i].rs3;
      wb_valid = vecs[i].wbv; wb_rd = {vecs[i].wb1, vecs[i].wb0};
      #1;
      chk($sformatf("v%0d_ready", i), {31'b0, issue_ready}, {31'b0, vecs[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), reg_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_err", i), {31'b0, underflow_err}, {31'b0, vecs[i].exp_err});
    end

    @(negedge clk);
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_dep = '0; wb_valid = '0;

    // WAW_ALLOW=1: fill rd=3 to saturation, then retire two at once.
    w_rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      w_drive(1'b1, 5'd3, 2'b00, 5'd0, 5'd0);
      chk($sformatf("waw_fill%0d", i), {31'b0, w_ready}, 32'd1);
    end
    w_drive(1'b1, 5'd3, 2'b00, 5'd0, 5'd0);
    chk("waw_saturated", {31'b0, w_ready}, 32'd0);
    chk("waw_busy3", w_busy, 32'h8);
    w_drive(1'b0, 5'd0, 2'b11, 5'd3, 5'd3);                // 7 -> 5
    w_drive(1'b1, 5'd3, 2'b00, 5'd0, 5'd0);
    chk("waw_after_wb_a", {31'b0, w_ready}, 32'd1);        // 5 -> 6
    w_drive(1'b1, 5'd3, 2'b00, 5'd0, 5'd0);
    chk("waw_after_wb_b", {31'b0, w_ready}, 32'd1);        // 6 -> 7
    w_drive(1'b1, 5'd3, 2'b00, 5'd0, 5'd0);
    chk("waw_after_wb_sat", {31'b0, w_ready}, 32'd0);

    // Same-cycle issue and writeback to rd=7 leaves the counter at 1.
    w_drive(1'b1, 5'd7, 2'b00, 5'd0, 5'd0);
    chk("same_cyc_first", {31'b0, w_ready}, 32'd1);
    w_drive(1'b1, 5'd7, 2'b10, 5'd0, 5'd7);
    chk("same_cyc_issue", {31'b0, w_ready}, 32'd1);
    w_drive(1'b0, 5'd0, 2'b01, 5'd7, 5'd0);
    chk("same_cyc_busy7", {31'b0, w_busy[7]}, 32'd1);
    w_drive(1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
    chk("same_cyc_drain", {31'b0, w_busy[7]}, 32'd0);
    chk("same_cyc_noerr", {31'b0, w_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
